score_tracker: RTL and testbench

Tallies completed tic-tac-toe games and drives the four-digit seven-segment display. Sits downstream of the game-state stage: consumes its 3-bit game status, detects each game-end transition exactly once, and keeps saturating two-digit BCD counts of X wins, O wins and draws. Its registered 16-bit BCD word feeds the display driver directly. It alternates between a wins page and a draws page, either under switch control or by automatic rotation.

---
 rtl/score_tracker_if.sv | 27 ++
 rtl/score_tracker.sv | 138 +++++++++++++
 tb/tb_score_tracker.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/score_tracker_if.sv
// ----------------------------------------------------------------------------
// score_tracker_if
// Groups the game-status inputs, display controls and display outputs of the
// score tracker. clk and rst stay outside as plain module ports.
//   master : upstream / test side (drives en, status and controls)
//   slave  : score_tracker (drives disp_value, page, result_pulse)
// ----------------------------------------------------------------------------
interface score_tracker_if;
  logic        en;           // one-clk logic-rate enable
  logic [2:0]  game_status;  // 000 playing, 001 X won, 010 O won, 011 draw
  logic        clr_scores;   // zero all counters on an en tick
  logic        auto_rot;     // 1 = rotate pages automatically
  logic        page_sel;     // manual page: 0 wins, 1 draws
  logic [15:0] disp_value;   // four BCD digits, MSD first
  logic        page;         // page currently shown
  logic        result_pulse; // one clk per counted game end

  modport master (
    output en, game_status, clr_scores, auto_rot, page_sel,
    input  disp_value, page, result_pulse
  );

  modport slave (
    input  en, game_status, clr_scores, auto_rot, page_sel,
    output disp_value, page, result_pulse
  );
endinterface

// File: rtl/score_tracker.sv
// ----------------------------------------------------------------------------
// score_tracker
// Counts finished tic-tac-toe games (X wins, O wins, draws) as saturating
// two-digit BCD values and presents them on a four-digit display word that
// alternates between a wins page and a draws page.
// Ports:
//   clk  - master clock
//   rst  - synchronous active-high reset, overrides everything
//   bus  - score_tracker_if.slave: en, game_status, clr_scores, auto_rot,
//          page_sel in; disp_value, page, result_pulse out
// Parameters:
//   ROTATE_TICKS - en ticks per page in auto-rotate mode (>= 1)
//   SAT          - BCD saturation value of each counter
// ----------------------------------------------------------------------------
module score_tracker #(
  parameter int         ROTATE_TICKS = 200,
  parameter logic [7:0] SAT          = 8'h99
) (
  input  logic           clk,
  input  logic           rst,
  score_tracker_if.slave bus
);

  typedef enum logic {
    WINS  = 1'b0,
    DRAWS = 1'b1
  } page_e;

  // A single-tick rotation still needs a one-bit counter to exist.
  localparam int                ROT_W    = (ROTATE_TICKS > 1) ? $clog2(ROTATE_TICKS) : 1;
  localparam logic [ROT_W-1:0]  ROT_LAST = ROT_W'(ROTATE_TICKS - 1);

  logic [7:0]       x_wins_q, x_wins_d;
  logic [7:0]       o_wins_q, o_wins_d;
  logic [7:0]       draws_q,  draws_d;
  logic             armed_q,  armed_d;
  page_e            state_q,  state_d;
  logic [ROT_W-1:0] rot_q,    rot_d;
  logic [15:0]      disp_q,   disp_d;
  logic             page_q,   page_d;
  logic             pulse_q,  pulse_d;

  logic             game_end;

  // Two-digit BCD increment that holds at SAT instead of wrapping.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == SAT)           return v;
    if (v[3:0] == 4'd9)     return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign game_end = (bus.game_status == 3'b001) ||
                    (bus.game_status == 3'b010) ||
                    (bus.game_status == 3'b011);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    x_wins_d = x_wins_q;
    o_wins_d = o_wins_q;
    draws_d  = draws_q;
    armed_d  = armed_q;
    state_d  = state_q;
    rot_d    = rot_q;
    pulse_d  = 1'b0;

    if (bus.en) begin
      // Arming: a game end counts only once; playing status re-arms.
      // Reserved codes 1xx fall through both branches untouched.
      if (bus.game_status == 3'b000) begin
        armed_d = 1'b1;
      end else if (game_end && armed_q) begin
        armed_d = 1'b0;
        // A clear on the same tick swallows the game end entirely.
        if (!bus.clr_scores) begin
          pulse_d = 1'b1;
          unique case (bus.game_status)
            3'b001:  x_wins_d = bcd_inc(x_wins_q);
            3'b010:  o_wins_d = bcd_inc(o_wins_q);
            default: draws_d  = bcd_inc(draws_q);
          endcase
        end
      end

      if (bus.clr_scores) begin
        x_wins_d = 8'h00;
        o_wins_d = 8'h00;
        draws_d  = 8'h00;
      end

      // Page FSM: manual mode follows page_sel, auto mode toggles on wrap.
      if (!bus.auto_rot) begin
        state_d = page_e'(bus.page_sel);
        rot_d   = '0;
      end else if (rot_q == ROT_LAST) begin
        rot_d   = '0;
        state_d = (state_q == WINS) ? DRAWS : WINS;
      end else begin
        rot_d   = rot_q + ROT_W'(1);
      end
    end

    // Display is refreshed every clk from the current counters and page.
    disp_d = (state_q == DRAWS) ? {8'hDD, draws_q} : {x_wins_q, o_wins_q};
    page_d = state_q;
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch and is
  // simply the highest-priority condition; state updates use <= only.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_wins_q <= 8'h00;
      o_wins_q <= 8'h00;
      draws_q  <= 8'h00;
      armed_q  <= 1'b1;
      state_q  <= WINS;
      rot_q    <= '0;
      disp_q   <= 16'h0000;
      page_q   <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      x_wins_q <= x_wins_d;
      o_wins_q <= o_wins_d;
      draws_q  <= draws_d;
      armed_q  <= armed_d;
      state_q  <= state_d;
      rot_q    <= rot_d;
      disp_q   <= disp_d;
      page_q   <= page_d;
      pulse_q  <= pulse_d;
    end
  end

  assign bus.disp_value   = disp_q;
  assign bus.page         = page_q;
  assign bus.result_pulse = pulse_q;

endmodule

// File: tb/tb_score_tracker.sv
// ----------------------------------------------------------------------------
// tb_score_tracker
// Directed stimulus for score_tracker with ROTATE_TICKS = 3. A model tracks
// the scores as plain decimal integers and the page as a bit; a compare
// process checks disp_value, page and result_pulse on every negedge, and
// literal checks pin the model at the interesting points.
// ----------------------------------------------------------------------------
module tb_score_tracker;

  localparam int ROT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  score_tracker_if bus ();

  score_tracker #(.ROTATE_TICKS(ROT), .SAT(8'h99)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model state (decimal counts) and the outputs it predicts.
  int          m_x, m_o, m_d, m_rot;
  bit          m_armed, m_page;
  logic [15:0] exp_disp;
  logic        exp_page, exp_pulse;
  bit          chk_on = 1'b0;
  int          pulses;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  // Compare process: DUT outputs against the model every cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      check("disp_value",   bus.disp_value,          exp_disp);
      check("page",         {15'd0, bus.page},         {15'd0, exp_page});
      check("result_pulse", {15'd0, bus.result_pulse}, {15'd0, exp_pulse});
    end
  end

  // One clk cycle: drive inputs, advance the model, wait for the edge.
  task automatic step(input bit e, input logic [2:0] st, input bit clr,
                      input bit ar, input bit ps);
    logic [15:0] nd;
    bit          np, npl;
    bus.en = e; bus.game_status = st; bus.clr_scores = clr;
    bus.auto_rot = ar; bus.page_sel = ps;
    nd  = m_page ? {8'hDD, to_bcd(m_d)} : {to_bcd(m_x), to_bcd(m_o)};
    np  = m_page;
    npl = 1'b0;
    if (e) begin
      if (st == 3'b000) m_armed = 1'b1;
      else if (st <= 3'b011 && m_armed) begin
        m_armed = 1'b0;
        if (!clr) begin
          npl = 1'b1;
          if (st == 3'b001 && m_x < 99) m_x++;
          if (st == 3'b010 && m_o < 99) m_o++;
          if (st == 3'b011 && m_d < 99) m_d++;
        end
      end
      if (clr) begin m_x = 0; m_o = 0; m_d = 0; end
      if (!ar) begin
        m_page = ps; m_rot = 0;
      end else begin
        m_rot++;
        if (m_rot == ROT) begin m_rot = 0; m_page = ~m_page; end
      end
    end
    @(posedge clk); #1;
    exp_disp = nd; exp_page = np; exp_pulse = npl;
    if (bus.result_pulse) pulses++;
  endtask

  task automatic idle();
    step(1'b0, 3'b000, 1'b0, bus.auto_rot, bus.page_sel);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.en = 1'b0; bus.game_status = 3'b000; bus.clr_scores = 1'b0;
    bus.auto_rot = 1'b0; bus.page_sel = 1'b0;
    m_x = 0; m_o = 0; m_d = 0; m_rot = 0; m_armed = 1'b1; m_page = 1'b0;
    @(posedge clk); #1;
    exp_disp = 16'h0000; exp_page = 1'b0; exp_pulse = 1'b0;
    rst = 1'b0;
    chk_on = 1'b1;
  endtask

  task automatic win(input logic [2:0] st);
    step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
    step(1'b1, st,     1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state.
    do_reset();
    check("rst_disp",  bus.disp_value, 16'h0000);
    check("rst_page",  {15'd0, bus.page}, 16'd0);
    check("rst_pulse", {15'd0, bus.result_pulse}, 16'd0);

    // X win held for 50 ticks counts once.
    step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 50; i++) step(1'b1, 3'b001, 1'b0, 1'b0, 1'b0);
    idle();
    check("held_win_pulses", 16'(pulses), 16'd1);
    check("held_win_disp",   bus.disp_value, 16'h0100);

    // Mixed results, draws page then wins page.
    do_reset();
    step(1'b1, 3'b001, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'b000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'b010, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'b000, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'b011, 1'b0, 1'b0, 1'b1);
    idle();
    check("draws_page", bus.disp_value, 16'hDD01);
    step(1'b1, 3'b011, 1'b0, 1'b0, 1'b0);
    idle();
    check("wins_page", bus.disp_value, 16'h0101);

    // BCD carry and saturation.
    do_reset();
    for (int i = 0; i < 9; i++) win(3'b001);
    idle();
    check("x_09", {8'h00, bus.disp_value[15:8]}, 16'h0009);
    win(3'b001);
    idle();
    check("x_10_carry", {8'h00, bus.disp_value[15:8]}, 16'h0010);
    for (int i = 0; i < 89; i++) win(3'b001);
    idle();
    check("x_99", {8'h00, bus.disp_value[15:8]}, 16'h0099);
    win(3'b001);
    check("sat_pulse", {15'd0, bus.result_pulse}, 16'd1);
    idle();
    check("x_sat_hold", {8'h00, bus.disp_value[15:8]}, 16'h0099);

    // Clear on the same tick as a game end.
    do_reset();
    win(3'b001);
    step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'b010, 1'b1, 1'b0, 1'b0);
    check("clr_no_pulse", {15'd0, bus.result_pulse}, 16'd0);
    idle();
    check("clr_zero", bus.disp_value, 16'h0000);
    pulses = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
    check("clr_consumed", 16'(pulses), 16'd0);
    win(3'b010);
    idle();
    check("o_after_clr", bus.disp_value, 16'h0001);

    // Reserved code is ignored.
    step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'b101, 1'b0, 1'b0, 1'b0);
    check("rsvd_no_pulse", {15'd0, bus.result_pulse}, 16'd0);
    step(1'b1, 3'b001, 1'b0, 1'b0, 1'b0);
    check("after_rsvd_pulse", {15'd0, bus.result_pulse}, 16'd1);
    idle();
    check("after_rsvd_disp", bus.disp_value, 16'h0101);

    // Auto rotation every 3 en ticks, with an en gap.
    for (int i = 0; i < 3; i++) step(1'b1, 3'b000, 1'b0, 1'b1, 1'b0);
    check("rot_before", {15'd0, bus.page}, 16'd0);
    step(1'b1, 3'b000, 1'b0, 1'b1, 1'b0);
    check("rot_toggled", {15'd0, bus.page}, 16'd1);
    check("rot_disp", bus.disp_value, 16'hDD00);
    step(1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
    step(1'b1, 3'b000, 1'b0, 1'b1, 1'b0);
    step(1'b1, 3'b000, 1'b0, 1'b1, 1'b0);
    step(1'b1, 3'b000, 1'b0, 1'b1, 1'b0);
    check("rot_back", {15'd0, bus.page}, 16'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 3'b000, 1'b0, 1'b1, 1'b0);
    // Drop auto_rot while on the draws page.
    step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
    check("manual_pre", {15'd0, bus.page}, 16'd1);
    idle();
    check("manual_page0", {15'd0, bus.page}, 16'd0);

    // Reset in the middle of rotation.
    for (int i = 0; i < 4; i++) step(1'b1, 3'b000, 1'b0, 1'b1, 1'b0);
    do_reset();
    check("mid_rst_page", {15'd0, bus.page}, 16'd0);
    check("mid_rst_disp", bus.disp_value, 16'h0000);
    idle();
    idle();
    check("post_rst_disp", bus.disp_value, 16'h0000);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected end before 1 ms");
    $fatal(1, "watchdog");
  end

endmodule
